// File: rtl/nios2_onchip_pkg.sv
// Shared constants for the Nios II dual-port on-chip RAM.
package nios2_onchip_pkg;

   localparam int unsigned DEF_DATA_W       = 32;
   localparam int unsigned DEF_ADDR_W       = 10;
   localparam int unsigned DEF_NUM_WORDS    = 1024;
   localparam int unsigned MIN_READ_LATENCY = 1;
   localparam int unsigned MAX_READ_LATENCY = 2;
   localparam int unsigned BYTE_W           = 8;

   // Number of byte lanes in a word of the given width.
   function automatic int unsigned be_w(input int unsigned data_w);
      return data_w / BYTE_W;
   endfunction

endpackage

// File: rtl/nios2_onchip_rdpipe.sv
// Per-port read pipeline: LATENCY stages of data/valid, frozen while clken is low.
module nios2_onchip_rdpipe
   import nios2_onchip_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned LATENCY = MIN_READ_LATENCY
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clken,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] readdata,
   output logic              readdatavalid
);

   logic [LATENCY-1:0]             vld;
   logic [LATENCY-1:0][DATA_W-1:0] dat;

   // Data registers only load alongside a valid bit, so the output holds the last read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld <= '0;
         dat <= '0;
      end else if (clken) begin
         vld[0] <= in_valid;
         if (in_valid) dat[0] <= in_data;
         for (int i = 1; i < int'(LATENCY); i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) dat[i] <= dat[i-1];
         end
      end
   end

   assign readdata      = dat[LATENCY-1];
   assign readdatavalid = vld[LATENCY-1];

endmodule

// File: rtl/nios2_onchip_ram_dp.sv
// True-dual-port byte-enabled on-chip RAM with Avalon-MM style ports s1 and s2.
module nios2_onchip_ram_dp
   import nios2_onchip_pkg::*;
#(
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned NUM_WORDS    = DEF_NUM_WORDS,
   parameter int unsigned READ_LATENCY = MIN_READ_LATENCY,
   parameter              INIT_FILE    = "nios2_onchip_memory.hex"
) (
   input  logic                      clk,
   input  logic                      reset_n,

   input  logic [ADDR_W-1:0]         s1_address,
   input  logic [be_w(DATA_W)-1:0]   s1_byteenable,
   input  logic                      s1_chipselect,
   input  logic                      s1_read,
   input  logic                      s1_write,
   input  logic                      s1_clken,
   input  logic [DATA_W-1:0]         s1_writedata,
   output logic [DATA_W-1:0]         s1_readdata,
   output logic                      s1_readdatavalid,

   input  logic [ADDR_W-1:0]         s2_address,
   input  logic [be_w(DATA_W)-1:0]   s2_byteenable,
   input  logic                      s2_chipselect,
   input  logic                      s2_read,
   input  logic                      s2_write,
   input  logic                      s2_clken,
   input  logic [DATA_W-1:0]         s2_writedata,
   output logic [DATA_W-1:0]         s2_readdata,
   output logic                      s2_readdatavalid
);

   localparam int unsigned BE_W  = be_w(DATA_W);
   localparam int unsigned DEPTH = NUM_WORDS;
   localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int unsigned LAT   = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                   (READ_LATENCY < MIN_READ_LATENCY) ? MIN_READ_LATENCY :
                                   READ_LATENCY;

   logic [DATA_W-1:0] mem [NUM_WORDS];

   logic              s1_inrange, s2_inrange;
   logic              s1_wr, s2_wr, s1_rd, s2_rd;
   logic [IDX_W-1:0]  s1_idx, s2_idx;
   logic [DATA_W-1:0] s1_rword, s2_rword;

   // A write wins over a simultaneous read; out-of-range addresses never touch the array.
   always_comb begin
      s1_inrange = 32'(s1_address) < DEPTH;
      s2_inrange = 32'(s2_address) < DEPTH;
      s1_idx     = IDX_W'(s1_address);
      s2_idx     = IDX_W'(s2_address);
      s1_wr      = s1_chipselect & s1_clken & s1_write & s1_inrange;
      s2_wr      = s2_chipselect & s2_clken & s2_write & s2_inrange;
      s1_rd      = s1_chipselect & s1_clken & s1_read & ~s1_write;
      s2_rd      = s2_chipselect & s2_clken & s2_read & ~s2_write;
      s1_rword   = s1_inrange ? mem[s1_idx] : '0;
      s2_rword   = s2_inrange ? mem[s2_idx] : '0;
   end

   // s1 lanes are assigned last so they override s2 on a same-address collision.
   always_ff @(posedge clk) begin
      for (int b = 0; b < int'(BE_W); b++) begin
         if (s2_wr && s2_byteenable[b]) mem[s2_idx][b*BYTE_W +: BYTE_W] <= s2_writedata[b*BYTE_W +: BYTE_W];
         if (s1_wr && s1_byteenable[b]) mem[s1_idx][b*BYTE_W +: BYTE_W] <= s1_writedata[b*BYTE_W +: BYTE_W];
      end
   end

   nios2_onchip_rdpipe #(.DATA_W(DATA_W), .LATENCY(LAT)) u_s1_rdpipe (
      .clk           (clk),
      .reset_n       (reset_n),
      .clken         (s1_clken),
      .in_valid      (s1_rd),
      .in_data       (s1_rword),
      .readdata      (s1_readdata),
      .readdatavalid (s1_readdatavalid)
   );

   nios2_onchip_rdpipe #(.DATA_W(DATA_W), .LATENCY(LAT)) u_s2_rdpipe (
      .clk           (clk),
      .reset_n       (reset_n),
      .clken         (s2_clken),
      .in_valid      (s2_rd),
      .in_data       (s2_rword),
      .readdata      (s2_readdata),
      .readdatavalid (s2_readdatavalid)
   );

endmodule

// File: tb/tb_nios2_onchip_ram_dp.sv
// Bench for nios2_onchip_ram_dp: directed vector table, corner sequences and a random run vs a queue model.
module tb_nios2_onchip_ram_dp;

   localparam int NW  = 768;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  s1_address, s2_address;
   logic [3:0]  s1_byteenable, s2_byteenable;
   logic        s1_chipselect, s1_read, s1_write, s1_clken;
   logic        s2_chipselect, s2_read, s2_write, s2_clken;
   logic [31:0] s1_writedata, s2_writedata;
   logic [31:0] s1_readdata, s2_readdata;
   logic        s1_readdatavalid, s2_readdatavalid;

   nios2_onchip_ram_dp #(
      .DATA_W(32), .ADDR_W(10), .NUM_WORDS(NW), .READ_LATENCY(LAT), .INIT_FILE("")
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
      .s1_read(s1_read), .s1_write(s1_write), .s1_clken(s1_clken), .s1_writedata(s1_writedata),
      .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
      .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
      .s2_read(s2_read), .s2_write(s2_write), .s2_clken(s2_clken), .s2_writedata(s2_writedata),
      .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: word array plus per-port list of reads aging in clken edges.
   typedef struct { logic [31:0] data; int age; } pend_t;
   pend_t       pq [2][$];
   logic [31:0] mdl [NW];
   logic        exp_v [2];
   logic [31:0] exp_d [2];
   logic        m_cs [2], m_ck [2], m_rd [2], m_wr [2];
   logic [9:0]  m_a [2];
   logic [3:0]  m_be [2];
   logic [31:0] m_wd [2], m_rdw [2];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < 2; p++) begin
            pq[p].delete();
            exp_v[p] = 1'b0;
            exp_d[p] = 32'h0;
         end
      end else begin
         m_cs[0] = s1_chipselect; m_ck[0] = s1_clken; m_rd[0] = s1_read; m_wr[0] = s1_write;
         m_a[0]  = s1_address;    m_be[0] = s1_byteenable; m_wd[0] = s1_writedata;
         m_cs[1] = s2_chipselect; m_ck[1] = s2_clken; m_rd[1] = s2_read; m_wr[1] = s2_write;
         m_a[1]  = s2_address;    m_be[1] = s2_byteenable; m_wd[1] = s2_writedata;
         for (int p = 0; p < 2; p++)
            m_rdw[p] = (int'(m_a[p]) < NW) ? mdl[m_a[p]] : 32'h0;
         for (int p = 0; p < 2; p++) begin
            if (m_ck[p]) begin
               if (pq[p].size() > 0 && pq[p][0].age == LAT) void'(pq[p].pop_front());
               for (int i = 0; i < pq[p].size(); i++) pq[p][i].age = pq[p][i].age + 1;
               if (m_cs[p] && m_rd[p] && !m_wr[p]) pq[p].push_back('{data: m_rdw[p], age: 1});
               exp_v[p] = (pq[p].size() > 0 && pq[p][0].age == LAT);
               if (exp_v[p]) exp_d[p] = pq[p][0].data;
            end
         end
         // s2 first, then s1, so s1 lanes win a collision.
         for (int p = 1; p >= 0; p--) begin
            if (m_cs[p] && m_ck[p] && m_wr[p] && int'(m_a[p]) < NW)
               for (int b = 0; b < 4; b++)
                  if (m_be[p][b]) mdl[m_a[p]][8*b +: 8] = m_wd[p][8*b +: 8];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("s1_valid_vs_model", 32'(s1_readdatavalid), 32'(exp_v[0]));
         check("s1_data_vs_model",  s1_readdata,           exp_d[0]);
         check("s2_valid_vs_model", 32'(s2_readdatavalid), 32'(exp_v[1]));
         check("s2_data_vs_model",  s2_readdata,           exp_d[1]);
      end
   end

   // Issue one s2 read, optionally stall clken for hold cycles, return edges to valid and data.
   task automatic s2_read_wait(input logic [9:0] a, input int hold, output int lat, output logic [31:0] d);
      s2_chipselect = 1'b1; s2_clken = 1'b1; s2_read = 1'b1; s2_write = 1'b0; s2_address = a;
      tick();
      lat = 1;
      s2_read = 1'b0; s1_write = 1'b0; s1_read = 1'b0;
      if (hold > 0) begin
         s2_clken = 1'b0;
         repeat (hold) begin tick(); lat++; end
         s2_clken = 1'b1;
      end
      while (!s2_readdatavalid && lat < 20) begin tick(); lat++; end
      d = s2_readdata;
   endtask

   typedef struct {
      logic w1; logic [9:0] a1; logic [3:0] be1; logic [31:0] d1;
      logic w2; logic [9:0] a2; logic [3:0] be2; logic [31:0] d2;
      logic [9:0] ra; logic [31:0] exp;
   } vec_t;
   vec_t tbl [8];

   initial begin
      int lat;
      logic [31:0] d;
      tbl[0] = '{1'b1, 10'h005, 4'hF, 32'hDEADBEEF, 1'b0, 10'h000, 4'h0, 32'h0,        10'h005, 32'hDEADBEEF};
      tbl[1] = '{1'b1, 10'h010, 4'h3, 32'h11111111, 1'b1, 10'h010, 4'hF, 32'h22222222, 10'h010, 32'h22221111};
      tbl[2] = '{1'b1, 10'h2FF, 4'hF, 32'hCAFEF00D, 1'b0, 10'h000, 4'h0, 32'h0,        10'h2FF, 32'hCAFEF00D};
      tbl[3] = '{1'b1, 10'h300, 4'hF, 32'hFFFFFFFF, 1'b0, 10'h000, 4'h0, 32'h0,        10'h300, 32'h00000000};
      tbl[4] = '{1'b0, 10'h000, 4'h0, 32'h0,        1'b0, 10'h000, 4'h0, 32'h0,        10'h2FF, 32'hCAFEF00D};
      tbl[5] = '{1'b0, 10'h000, 4'h0, 32'h0,        1'b1, 10'h040, 4'h5, 32'hA1B2C3D4, 10'h040, 32'h00B200D4};
      tbl[6] = '{1'b1, 10'h041, 4'hC, 32'h12345678, 1'b1, 10'h041, 4'h3, 32'h9ABCDEF0, 10'h041, 32'h1234DEF0};
      tbl[7] = '{1'b0, 10'h000, 4'h0, 32'h0,        1'b1, 10'h3FF, 4'hF, 32'h55555555, 10'h3FF, 32'h00000000};

      s1_address = '0; s1_byteenable = '0; s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_clken = 1; s1_writedata = '0;
      s2_address = '0; s2_byteenable = '0; s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_clken = 1; s2_writedata = '0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #3;
      check("reset_s1_valid", 32'(s1_readdatavalid), 32'h0);
      check("reset_s1_data",  s1_readdata,           32'h0);
      check("reset_s2_valid", 32'(s2_readdatavalid), 32'h0);
      check("reset_s2_data",  s2_readdata,           32'h0);
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      tick();
      chk_en = 1'b1;

      // Zero the whole implemented depth through both ports.
      s1_chipselect = 1; s2_chipselect = 1; s1_write = 1; s2_write = 1;
      s1_byteenable = 4'hF; s2_byteenable = 4'hF; s1_writedata = '0; s2_writedata = '0;
      for (int a = 0; a < NW; a += 2) begin
         s1_address = 10'(a); s2_address = 10'(a + 1);
         tick();
      end
      s1_write = 0; s2_write = 0;

      foreach (tbl[i]) begin
         if (tbl[i].w1 || tbl[i].w2) begin
            s1_write = tbl[i].w1; s1_address = tbl[i].a1; s1_byteenable = tbl[i].be1; s1_writedata = tbl[i].d1;
            s2_write = tbl[i].w2; s2_address = tbl[i].a2; s2_byteenable = tbl[i].be2; s2_writedata = tbl[i].d2;
            tick();
            s1_write = 0; s2_write = 0;
         end
         s2_read_wait(tbl[i].ra, 0, lat, d);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
         check($sformatf("vec%0d_data", i),    d,         tbl[i].exp);
      end

      // Mixed-port read-during-write returns old data, the next read sees the new word.
      s1_write = 1; s1_address = 10'h020; s1_byteenable = 4'hF; s1_writedata = 32'hAAAA5555;
      tick();
      s1_writedata = 32'h12345678;
      s2_read_wait(10'h020, 0, lat, d);
      check("rdw_old_data", d, 32'hAAAA5555);
      s2_read_wait(10'h020, 0, lat, d);
      check("rdw_new_data", d, 32'h12345678);

      // Three-cycle clken stall mid-pipeline.
      s2_read_wait(10'h005, 3, lat, d);
      check("stall_latency", 32'(lat), 32'd5);
      check("stall_data",    d,        32'hDEADBEEF);

      // Reset with reads in flight on both ports.
      s1_chipselect = 1; s1_read = 1; s1_address = 10'h005;
      s2_chipselect = 1; s2_read = 1; s2_address = 10'h010;
      tick();
      s1_read = 0; s2_read = 0;
      #2 reset_n = 1'b0;
      #1;
      check("rst_flight_s1_valid", 32'(s1_readdatavalid), 32'h0);
      check("rst_flight_s1_data",  s1_readdata,           32'h0);
      check("rst_flight_s2_valid", 32'(s2_readdatavalid), 32'h0);
      check("rst_flight_s2_data",  s2_readdata,           32'h0);
      tick();
      #2 reset_n = 1'b1;
      repeat (4) begin
         tick();
         check("post_rst_s1_valid", 32'(s1_readdatavalid), 32'h0);
         check("post_rst_s2_valid", 32'(s2_readdatavalid), 32'h0);
      end
      s2_read_wait(10'h005, 0, lat, d);
      check("post_rst_keep_005", d, 32'hDEADBEEF);
      s2_read_wait(10'h010, 0, lat, d);
      check("post_rst_keep_010", d, 32'h22221111);

      // Random traffic checked cycle by cycle against the model.
      for (int n = 0; n < 600; n++) begin
         s1_chipselect = ($urandom % 8) != 0;  s2_chipselect = ($urandom % 8) != 0;
         s1_clken      = ($urandom % 6) != 0;  s2_clken      = ($urandom % 6) != 0;
         s1_read       = 1'($urandom);         s2_read       = 1'($urandom);
         s1_write      = ($urandom % 3) == 0;  s2_write      = ($urandom % 3) == 0;
         s1_address    = 10'($urandom_range(0, 799));
         s2_address    = ($urandom % 4 == 0) ? s1_address : 10'($urandom_range(0, 799));
         s1_byteenable = 4'($urandom);         s2_byteenable = 4'($urandom);
         s1_writedata  = $urandom;             s2_writedata  = $urandom;
         tick();
      end
      s1_chipselect = 0; s2_chipselect = 0; s1_clken = 1; s2_clken = 1;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1);
   end

endmodule

// File: doc/nios2_onchip_ram_dp.md
NIOS2_ONCHIP_RAM_DP -- requirements
Module: nios2_onchip_ram_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits (multiple of 8, 8..128).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning word-address width per port.
REQ-003 SHALL have parameter NUM_WORDS, default 1024, meaning implemented depth (<= 2**ADDR_W).
REQ-004 SHALL have parameter READ_LATENCY, default 1, meaning read pipeline depth (1 or 2).
REQ-005 SHALL have parameter INIT_FILE, default "nios2_onchip_memory.hex", meaning hex init image ("" = uninitialised).
REQ-006 SHALL have one clock and asynchronous active-low reset: clk  in  1  sole clock, all logic rising-edge; reset_n  in  1  async assert, active low.
REQ-007 SHALL provide per port p in {s1,s2}: p_address  in  ADDR_W  word address.
REQ-008 SHALL provide p_byteenable  in  DATA_W/8  byte write mask.
REQ-009 SHALL provide p_chipselect, p_read, p_write  in  1 each  Avalon-MM request qualifiers.
REQ-010 SHALL provide p_clken  in  1  port clock enable.
REQ-011 SHALL provide p_writedata  in  DATA_W  write data.
REQ-012 SHALL provide p_readdata  out  DATA_W  read data; p_readdatavalid  out  1  read data qualifier.

Function
REQ-013 SHALL accept a request on port p only when p_chipselect=1 and p_clken=1; no waitrequest, one request per cycle per port.
REQ-014 SHALL write bytes selected by p_byteenable at p_address on the accepting edge; unselected bytes unchanged.
REQ-015 SHALL treat p_read=1 and p_write=1 together as write only; no readdatavalid generated.
REQ-016 SHALL present p_readdata with p_readdatavalid=1 exactly READ_LATENCY accepted-clken cycles after read acceptance, for one cycle.
REQ-017 SHALL freeze port p read pipeline (data and valid held) while p_clken=0; reads in flight are not lost.
REQ-018 SHALL hold p_readdata at last valid value when p_readdatavalid=0.
REQ-019 SHALL ignore writes with p_address >= NUM_WORDS; reads there return all-zero data with readdatavalid asserted normally.
REQ-020 SHALL give s1 priority when both ports write the same address in the same cycle: per byte, s1-enabled bytes take s1 data, bytes enabled only by s2 take s2 data.
REQ-021 SHALL return old data for mixed-port read-during-write (read on one port, write same address on other, same cycle).
REQ-022 SHALL return old data for same-address read on port p following a write on p in the prior cycle only if READ_LATENCY timing captures before write; otherwise new data -- decided: array read occurs at acceptance edge, so the prior-cycle write is visible (new data).
REQ-023 SHALL load INIT_FILE into the array at elaboration when non-empty; otherwise contents undefined.

Reset
REQ-024 SHALL on reset_n=0 clear both read pipelines: p_readdatavalid=0, p_readdata=0, within the same cycle (async).
REQ-025 SHALL NOT reset or re-initialise array contents; reads in flight at reset are discarded.
REQ-026 SHALL accept requests from the first rising clk edge after reset_n deasserts.

Structure
REQ-027 SHALL place shared constants (default widths, depth, READ_LATENCY limits, BE_W = DATA_W/8 derivation) in package nios2_onchip_pkg.
REQ-028 SHALL implement the per-port read-latency/valid pipeline as sub-module nios2_onchip_rdpipe, instantiated once per port.
REQ-029 SHALL infer the array as a single true-dual-port RAM with byte enables; no vendor primitive in RTL.

Verification
REQ-030 SHALL check: s1 write 0xDEADBEEF @0x005 be=0xF, then s2 read @0x005, READ_LATENCY=2 -> s2_readdatavalid pulses 2 cycles later with 0xDEADBEEF.
REQ-031 SHALL check: s1 write 0x11111111 and s2 write 0x22222222 @0x010, s1 be=0x3, s2 be=0xF, same cycle -> later read 0x22221111.
REQ-032 SHALL check: word @0x020=0xAAAA5555; s1 write 0x12345678 and s2 read @0x020 same cycle -> s2 returns 0xAAAA5555; next read returns 0x12345678.
REQ-033 SHALL check: s2 read issued, s2_clken dropped 3 cycles mid-pipeline -> readdatavalid delayed exactly 3 cycles, data intact.
REQ-034 SHALL check: NUM_WORDS=768, write 0xFFFFFFFF @0x300 then read @0x300 -> readdata 0x00000000, valid asserted; write @0x2FF unaffected.
REQ-035 SHALL check: reset_n asserted with reads in flight -> readdatavalid and readdata 0 immediately; no valid pulse after deassertion; array data preserved.
